// File: rtl/cpu_pkg.sv
// Shared front-end definitions: opcodes, issue FSM states, NOP encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/issue_frontend_if.sv
// Fetch/issue bus between the front end, the instruction SRAM and the
// mem subpipeline (ID inputs out, branch resolution in).
interface issue_frontend_if;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        branch_ctrl;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        stall;

  modport master (
    output pc_out, id_valid, id_pc, id_instr, stall,
    input  instr_in, branch_ctrl, branch_target
  );

  modport slave (
    input  pc_out, id_valid, id_pc, id_instr, stall,
    output instr_in, branch_ctrl, branch_target
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Destination scoreboard: one slot per in-flight stage, shifted on en,
// with a combinational match against up to three source registers.
module reg_scoreboard #(
  parameter int SB_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load_valid,
  input  logic [4:0] load_reg,
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  input  logic [4:0] src_c,
  output logic       match
);

  logic       valid [SB_DEPTH];
  logic [4:0] regs  [SB_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        valid[i] <= 1'b0;
        regs[i]  <= 5'd0;
      end
    end else if (en) begin
      valid[0] <= load_valid && (load_reg != 5'd0);
      regs[0]  <= load_reg;
      for (int i = 1; i < SB_DEPTH; i++) begin
        valid[i] <= valid[i-1];
        regs[i]  <= regs[i-1];
      end
    end
  end

  // The WR-stage slot writes the regfile this cycle and reads see it,
  // so only the younger slots can still block a consumer.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < SB_DEPTH - 1; i++) begin
      if (valid[i] && (regs[i] == src_a ||
                       regs[i] == src_b ||
                       regs[i] == src_c))
        match = 1'b1;
    end
  end

endmodule

// File: rtl/issue_frontend.sv
// Fetch/issue front end: PC, IF/ID register, RAW bubbles, branch shadow.
// Optional ISSUE_STATS_EN adds saturating haz_cnt/br_cnt outputs.
module issue_frontend
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          SB_DEPTH  = 4,
  parameter int          BR_SHADOW = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  issue_frontend_if.master bus
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0] haz_cnt,
  output logic [15:0] br_cnt
`endif
);

  localparam int CW = $clog2(BR_SHADOW + 1);

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [4:0]  dest, src_a, src_b;
  logic        branch;
  logic        is_imm;
  logic        hazard;
  logic        issue;
  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  assign op = bus.instr_in[31:26];
  assign rs = bus.instr_in[25:21];
  assign rt = bus.instr_in[20:16];
  assign rd = bus.instr_in[15:11];

  assign is_imm = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                             OP_ANDI, OP_ORI, OP_LUI};

  always_comb begin
    dest   = 5'd0;
    src_a  = rs;
    src_b  = 5'd0;
    branch = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        dest  = rd;
        src_b = rt;
      end
      is_imm, op == OP_LW: dest = rt;
      op == OP_SW: src_b = rt;
      op == OP_BEQ, op == OP_BNE: begin
        src_b  = rt;
        branch = 1'b1;
      end
      op == OP_BGTZ: branch = 1'b1;
      default: ;
    endcase
  end

  assign issue = en && (state == RUN) && !hazard;

  reg_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load_valid(issue),
    .load_reg  (dest),
    .src_a     (src_a),
    .src_b     (src_b),
    .src_c     (5'd0),
    .match     (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      id_pc    <= 32'h0;
      id_instr <= NOP;
      id_valid <= 1'b0;
      state    <= RUN;
      cnt      <= '0;
    end else if (en) begin
      if (state == RUN) begin
        if (!hazard) begin
          id_instr <= bus.instr_in;
          id_pc    <= pc;
          id_valid <= 1'b1;
          pc       <= pc + 32'd4;
          if (branch) begin
            state <= BR_WAIT;
            cnt   <= CW'(BR_SHADOW);
          end
        end else begin
          id_instr <= NOP;
          id_valid <= 1'b0;
        end
      end else begin
        id_instr <= NOP;
        id_valid <= 1'b0;
        cnt      <= cnt - 1'b1;
        if (bus.branch_ctrl)
          pc <= bus.branch_target;
        if (cnt == CW'(1))
          state <= RUN;
      end
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haz_cnt <= 16'd0;
      br_cnt  <= 16'd0;
    end else if (en) begin
      if (state == RUN && hazard && haz_cnt != 16'hFFFF)
        haz_cnt <= haz_cnt + 16'd1;
      if (state == BR_WAIT && br_cnt != 16'hFFFF)
        br_cnt <= br_cnt + 16'd1;
    end
  end
`endif

  assign bus.pc_out   = pc;
  assign bus.id_pc    = id_pc;
  assign bus.id_instr = id_instr;
  assign bus.id_valid = id_valid;
  assign bus.stall    = en && (state == BR_WAIT || hazard);

endmodule

// File: tb/tb_issue_frontend.sv
// Bench for issue_frontend: vector tables, directed corners and a random
// run against a cycle-count based issue model.
module tb_issue_frontend;

  localparam int SB_DEPTH  = 4;
  localparam int BR_SHADOW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  issue_frontend_if bus();
  logic [31:0] imem [0:255];

`ifdef ISSUE_STATS_EN
  logic [15:0] haz_cnt;
  logic [15:0] br_cnt;
`endif

  issue_frontend #(
    .RESET_PC (32'h0),
    .SB_DEPTH (SB_DEPTH),
    .BR_SHADOW(BR_SHADOW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bus  (bus)
`ifdef ISSUE_STATS_EN
    ,
    .haz_cnt(haz_cnt),
    .br_cnt (br_cnt)
`endif
  );

  assign bus.instr_in = imem[bus.pc_out[9:2]];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rd, input int rs,
                                       input int rt);
    r_op = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rt,
                                       input int rs, input int imm);
    i_op = {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Issue model: a register is readable SB_DEPTH-1 enabled edges after
  // its producer issued; a branch blocks the next BR_SHADOW enabled edges.
  logic [31:0] m_pc, m_idpc, m_idinstr;
  logic        m_valid;
  int          m_shadow, m_n, m_haz, m_br;
  int          ready_at [32];

  function automatic void m_decode(input logic [31:0] ins,
                                   output int d, output int s1,
                                   output int s2, output logic br);
    int op;
    op = int'(ins[31:26]);
    d  = 0;
    s1 = int'(ins[25:21]);
    s2 = 0;
    br = 1'b0;
    case (op)
      'h00: begin d = int'(ins[15:11]); s2 = int'(ins[20:16]); end
      'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0F, 'h23: d = int'(ins[20:16]);
      'h2B: s2 = int'(ins[20:16]);
      'h04, 'h05: begin s2 = int'(ins[20:16]); br = 1'b1; end
      'h07: br = 1'b1;
      default: ;
    endcase
  endfunction

  function automatic logic m_hazard(input logic [31:0] ins);
    int d, s1, s2;
    logic br;
    m_decode(ins, d, s1, s2, br);
    return (s1 != 0 && m_n < ready_at[s1]) ||
           (s2 != 0 && m_n < ready_at[s2]);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_idpc = 32'h0; m_idinstr = 32'h0; m_valid = 1'b0;
    m_shadow = 0; m_n = 0; m_haz = 0; m_br = 0;
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
  endtask

  task automatic model_edge(input logic [31:0] ins, input logic hz,
                            input logic b, input logic [31:0] t);
    int d, s1, s2;
    logic br;
    if (m_shadow > 0) begin
      m_valid = 1'b0; m_idinstr = 32'h0;
      if (b) m_pc = t;
      m_shadow--; m_br++;
    end else if (hz) begin
      m_valid = 1'b0; m_idinstr = 32'h0; m_haz++;
    end else begin
      m_decode(ins, d, s1, s2, br);
      m_valid = 1'b1; m_idpc = m_pc; m_idinstr = ins;
      if (d != 0) ready_at[d] = m_n + SB_DEPTH;
      m_pc = m_pc + 32'd4;
      if (br) m_shadow = BR_SHADOW;
    end
    m_n++;
  endtask

  task automatic step(input logic e, input logic b, input logic [31:0] t,
                      input string tag);
    logic [31:0] ins;
    logic hz;
    en = e; bus.branch_ctrl = b; bus.branch_target = t;
    #2;
    ins = imem[m_pc[9:2]];
    hz = m_hazard(ins);
    chk({tag, " stall"}, 32'(bus.stall), 32'(e && (m_shadow > 0 || hz)));
    @(posedge clk);
    if (e) model_edge(ins, hz, b, t);
    #1;
    chk({tag, " pc_out"}, bus.pc_out, m_pc);
    chk({tag, " id_valid"}, 32'(bus.id_valid), 32'(m_valid));
    chk({tag, " id_pc"}, bus.id_pc, m_idpc);
    chk({tag, " id_instr"}, bus.id_instr, m_idinstr);
  endtask

  typedef struct {
    logic        e;
    logic        bc;
    logic [31:0] tgt;
    logic        stall;
    logic        valid;
    logic [31:0] idpc;
    logic [31:0] pcout;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    en = v.e; bus.branch_ctrl = v.bc; bus.branch_target = v.tgt;
    #2;
    chk({tag, " stall"}, 32'(bus.stall), 32'(v.stall));
    @(posedge clk); #1;
    chk({tag, " id_valid"}, 32'(bus.id_valid), 32'(v.valid));
    chk({tag, " id_pc"}, bus.id_pc, v.idpc);
    chk({tag, " pc_out"}, bus.pc_out, v.pcout);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; bus.branch_ctrl = 1'b0;
    bus.branch_target = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t hv [6];
  vec_t bv [7];

  initial begin
    hv[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h4};
    hv[1] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4};
    hv[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4};
    hv[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4};
    hv[4] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h8};
    hv[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'hC};

    bv[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'h4};
    bv[1] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  32'h8};
    bv[2] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h8,  32'hC};
    bv[3] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h8,  32'hC};
    bv[4] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h8,  32'hC};
    bv[5] = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h8,  32'h40};
    bv[6] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 32'h44};

    bus.branch_ctrl = 1'b0;
    bus.branch_target = 32'h0;
    clear_mem();
    #1;
    chk("reset pc_out", bus.pc_out, 32'h0);
    chk("reset id_valid", 32'(bus.id_valid), 32'h0);
    chk("reset id_instr", bus.id_instr, 32'h0);
    chk("reset id_pc", bus.id_pc, 32'h0);

    // RAW pair: consumer waits SB_DEPTH-1 bubbles
    clear_mem();
    imem[0] = r_op(1, 2, 3);
    imem[1] = r_op(4, 1, 5);
    imem[2] = i_op(6'h0D, 7, 8, 5);
    apply_reset();
    for (int i = 0; i < 6; i++) run_vec(hv[i], $sformatf("haz%0d", i));

    // beq at 8, taken on the last shadow bubble
    clear_mem();
    imem[0]  = r_op(1, 2, 3);
    imem[1]  = i_op(6'h0D, 7, 8, 5);
    imem[2]  = i_op(6'h04, 10, 9, 16);
    imem[3]  = r_op(11, 12, 13);
    imem[16] = r_op(14, 15, 16);
    apply_reset();
    for (int i = 0; i < 7; i++) run_vec(bv[i], $sformatf("beqt%0d", i));

    // Same beq not taken: resumes at 0xC
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, "beqnt");

    // Independent stream, with branch_ctrl pulsed in RUN
    clear_mem();
    imem[0] = r_op(1, 2, 3);
    imem[1] = r_op(4, 5, 6);
    imem[2] = i_op(6'h0D, 7, 8, 5);
    apply_reset();
    step(1'b1, 1'b0, 32'h0, "ind0");
    step(1'b1, 1'b1, 32'h80, "ind1");
    step(1'b1, 1'b1, 32'h80, "ind2");
    step(1'b1, 1'b0, 32'h0, "ind3");

    // $0 as destination never creates a dependency
    clear_mem();
    imem[0] = r_op(0, 2, 3);
    imem[1] = r_op(4, 0, 5);
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, "zero");

    // en low mid-shadow, then shadow completes
    clear_mem();
    imem[0]  = r_op(1, 2, 3);
    imem[1]  = i_op(6'h0D, 7, 8, 5);
    imem[2]  = i_op(6'h04, 10, 9, 16);
    imem[16] = r_op(14, 15, 16);
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, "hold_a");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h80, "hold_off");
    step(1'b1, 1'b0, 32'h0, "hold_b");
    step(1'b1, 1'b1, 32'h40, "hold_c");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, "hold_d");

    // Async reset mid-branch abandons the redirect
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, "arst_a");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst pc_out", bus.pc_out, 32'h0);
    chk("arst id_valid", 32'(bus.id_valid), 32'h0);
    chk("arst id_instr", bus.id_instr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h80, "arst_b");

    // One hazard pair plus one branch
    clear_mem();
    imem[0] = r_op(1, 2, 3);
    imem[1] = r_op(4, 1, 5);
    imem[2] = i_op(6'h04, 10, 9, 16);
    apply_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, "stats");
`ifdef ISSUE_STATS_EN
    chk("haz_cnt", 32'(haz_cnt), 32'd3);
    chk("br_cnt", 32'(br_cnt), 32'd3);
`endif

    // Random program, random en / branch resolution
    for (int i = 0; i < 256; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 9))
        0, 1: op = 6'h00;
        2: op = 6'h08;
        3: op = 6'h0F;
        4: op = 6'h23;
        5: op = 6'h2B;
        6: op = 6'h04;
        7: op = 6'h05;
        8: op = 6'h07;
        default: op = 6'h02;
      endcase
      imem[i] = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 11'($urandom)};
    end
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      logic e, b;
      logic [31:0] t;
      e = ($urandom_range(0, 9) != 0);
      b = ($urandom_range(0, 3) == 0);
      t = 32'($urandom_range(0, 255)) << 2;
      step(e, b, t, "rnd");
    end
`ifdef ISSUE_STATS_EN
    chk("rnd haz_cnt", 32'(haz_cnt), 32'(m_haz));
    chk("rnd br_cnt", 32'(br_cnt), 32'(m_br));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
